// File: rtl/viterbi_conv_encoder_if.sv
// Handshake bundle for the K=7 rate-1/2 convolutional encoder.
// The master side drives frame control, input bits and output back-pressure.
interface viterbi_conv_encoder_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_sym;
  logic             out_last;
  logic             busy;
  logic             frame_done;

  modport master (
    output start, frame_len, in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_sym, out_last, busy, frame_done
  );

  modport slave (
    input  start, frame_len, in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_sym, out_last, busy, frame_done
  );
endinterface

// File: rtl/viterbi_conv_encoder.sv
// Streaming rate-1/2 K=7 convolutional encoder (171/133 octal) with zero-tail
// termination, so every frame returns the trellis to state 0.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; output register may still drain
// S_DATA | encoding information bits as they are handshaken in
// S_TAIL | flushing six zero bits; the sixth symbol carries out_last
module viterbi_conv_encoder #(
  parameter int         LEN_W = 16,
  parameter logic [6:0] G0    = 7'o171,
  parameter logic [6:0] G1    = 7'o133
) (
  input  logic                   clk,
  input  logic                   rst,
  viterbi_conv_encoder_if.slave  bus_io
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_TAIL = 2'd2
  } state_e;

  localparam logic [LEN_W-1:0] CNT_ONE   = LEN_W'(1);
  localparam logic [2:0]       TAIL_BITS = 3'd6;

  state_e           state_q, state_d;
  logic [5:0]       shreg_q, shreg_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       tail_cnt_q, tail_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       out_sym_q, out_sym_d;
  logic             out_last_q, out_last_d;
  logic             frame_done_q, frame_done_d;

  logic             out_free;
  logic             in_fire;
  logic             start_ok;
  logic             sym_load;
  logic             sym_last;
  logic             enc_u;
  logic [6:0]       win;

  // The output slot is usable when empty or when it drains this same cycle.
  assign out_free = !out_valid_q || bus_io.out_ready;
  assign in_fire  = (state_q == S_DATA) && out_free && bus_io.in_valid;
  assign start_ok = (state_q == S_IDLE) && !out_valid_q && bus_io.start;
  assign win      = {enc_u, shreg_q};

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    tail_cnt_d = tail_cnt_q;
    sym_load   = 1'b0;
    sym_last   = 1'b0;
    enc_u      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          bit_cnt_d  = bus_io.frame_len;
          tail_cnt_d = TAIL_BITS;
          shreg_d    = '0;
          state_d    = (bus_io.frame_len == '0) ? S_TAIL : S_DATA;
        end
      end

      S_DATA: begin
        if (in_fire) begin
          sym_load = 1'b1;
          enc_u    = bus_io.in_bit;
          shreg_d  = {bus_io.in_bit, shreg_q[5:1]};
          if (bit_cnt_q != '0) begin
            bit_cnt_d = bit_cnt_q - CNT_ONE;
          end
          if (bit_cnt_q <= CNT_ONE) begin
            tail_cnt_d = TAIL_BITS;
            state_d    = S_TAIL;
          end
        end
      end

      S_TAIL: begin
        if (out_free) begin
          sym_load = 1'b1;
          enc_u    = 1'b0;
          shreg_d  = {1'b0, shreg_q[5:1]};
          if (tail_cnt_q != 3'd0) begin
            tail_cnt_d = tail_cnt_q - 3'd1;
          end
          if (tail_cnt_q <= 3'd1) begin
            sym_last = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_sym_d    = out_sym_q;
    out_last_d   = out_last_q;
    frame_done_d = out_valid_q && bus_io.out_ready && out_last_q;

    if (sym_load) begin
      out_valid_d = 1'b1;
      out_sym_d   = {^(win & G0), ^(win & G1)};
      out_last_d  = sym_last;
    end else if (out_valid_q && bus_io.out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      tail_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_sym_q    <= 2'b00;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      tail_cnt_q   <= tail_cnt_d;
      out_valid_q  <= out_valid_d;
      out_sym_q    <= out_sym_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus_io.in_ready   = (state_q == S_DATA) && out_free;
  assign bus_io.out_valid  = out_valid_q;
  assign bus_io.out_sym    = out_sym_q;
  assign bus_io.out_last   = out_last_q;
  assign bus_io.busy       = (state_q != S_IDLE) || out_valid_q;
  assign bus_io.frame_done = frame_done_q;

endmodule

// File: tb/tb_viterbi_conv_encoder.sv
// Scoreboard bench for viterbi_conv_encoder: directed frames with hand-derived
// symbols plus a long random frame checked against a convolution model.
module tb_viterbi_conv_encoder;
  localparam int       LEN_W = 16;
  localparam bit [6:0] TG0   = 7'o171;
  localparam bit [6:0] TG1   = 7'o133;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  viterbi_conv_encoder_if #(.LEN_W(LEN_W)) bus ();
  viterbi_conv_encoder #(.LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus_io(bus));

  typedef struct packed {
    logic [1:0] sym;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   fd_cnt   = 0;
  int   pop_cnt  = 0;
  int   rdy_mode = 0;
  bit   ir_seen  = 1'b0;
  bit   prev_stall = 1'b0;
  bit   last_prev  = 1'b0;
  logic [1:0] prev_sym;
  logic       prev_last;
  bit   hist [7];

  logic [1:0] imp_seq [7]  = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
  logic [1:0] bp_seq  [10] = '{2'b11, 2'b10, 2'b00, 2'b10, 2'b01, 2'b01, 2'b00, 2'b01, 2'b10, 2'b11};
  logic [1:0] ign_seq [9]  = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11};
  bit         bp_bits [4]  = '{1'b1, 1'b0, 1'b1, 1'b1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: no response within the cycle budget", name);
  endtask

  task automatic push(input logic [1:0] s, input logic l);
    exp_t e;
    e.sym  = s;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Convolution model: hist[k] is the input bit k symbols ago.
  function automatic logic [1:0] ref_sym(input bit u);
    bit c0, c1;
    for (int k = 6; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = u;
    c0 = 1'b0;
    c1 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      c0 ^= TG0[6-k] & hist[k];
      c1 ^= TG1[6-k] & hist[k];
    end
    return {c0, c1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int len);
    int n = 0;
    while (bus.busy) begin
      tick();
      n++;
      if (n > 500) begin
        timeout_fail("start_wait");
        break;
      end
    end
    bus.start     = 1'b1;
    bus.frame_len = LEN_W'(len);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_bit(input bit b);
    int n = 0;
    bit acc;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    forever begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      if (acc) break;
      n++;
      if (n > 500) begin
        timeout_fail("in_handshake");
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 || bus.busy) begin
      tick();
      n++;
      if (n > 5000) begin
        timeout_fail("frame_drain");
        break;
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ~bus.out_ready;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: decoupled from stimulus, pops the scoreboard on each transfer.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      last_prev  = 1'b0;
    end else begin
      if (bus.frame_done || last_prev) begin
        check("frame_done", bus.frame_done, last_prev);
        if (bus.frame_done) begin
          fd_cnt++;
          check("busy_at_done", bus.busy, 0);
        end
      end
      if (bus.in_ready) ir_seen = 1'b1;
      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_sym", bus.out_sym, prev_sym);
        check("stall_last", bus.out_last, prev_last);
      end
      last_prev = bus.out_valid && bus.out_ready && bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_sym: got %b, required no symbol", bus.out_sym);
        end else begin
          mon_e = exp_q.pop_front();
          pop_cnt++;
          check("out_sym", bus.out_sym, mon_e.sym);
          check("out_last", bus.out_last, mon_e.last);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      if (prev_stall) begin
        prev_sym  = bus.out_sym;
        prev_last = bus.out_last;
        check("in_ready_stall", bus.in_ready, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0, p0, n;
    bus.start     = 1'b0;
    bus.frame_len = '0;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b1;

    #1 rst = 1'b1;
    #2;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sym", bus.out_sym, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_frame_done", bus.frame_done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();

    // Impulse frame
    for (int i = 0; i < 7; i++) push(imp_seq[i], i == 6);
    fd0 = fd_cnt;
    start_frame(1);
    check("in_ready_after_start", bus.in_ready, 1);
    send_bit(1'b1);
    check("one_cycle_latency", bus.out_valid, 1);
    wait_done();
    tick();
    check("impulse_frame_done_cnt", fd_cnt - fd0, 1);

    // Zero-length frame
    for (int i = 0; i < 6; i++) push(2'b00, i == 5);
    fd0 = fd_cnt;
    ir_seen = 1'b0;
    start_frame(0);
    wait_done();
    tick();
    check("zero_in_ready_seen", ir_seen, 0);
    check("zero_frame_done_cnt", fd_cnt - fd0, 1);

    // Back-pressure with toggling out_ready
    rdy_mode = 1;
    for (int i = 0; i < 10; i++) push(bp_seq[i], i == 9);
    fd0 = fd_cnt;
    start_frame(4);
    for (int i = 0; i < 4; i++) send_bit(bp_bits[i]);
    wait_done();
    tick();
    check("bp_frame_done_cnt", fd_cnt - fd0, 1);
    rdy_mode = 0;
    tick();

    // Start pulsed mid-frame with a different length is ignored
    for (int i = 0; i < 9; i++) push(ign_seq[i], i == 8);
    fd0 = fd_cnt;
    start_frame(3);
    send_bit(1'b1);
    bus.start     = 1'b1;
    bus.frame_len = LEN_W'(9);
    tick();
    bus.start = 1'b0;
    check("ign_busy", bus.busy, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    wait_done();
    tick();
    check("ign_frame_done_cnt", fd_cnt - fd0, 1);

    // Reset asserted during the tail of an impulse frame
    for (int i = 0; i < 7; i++) push(imp_seq[i], i == 6);
    p0 = pop_cnt;
    start_frame(1);
    send_bit(1'b1);
    n = 0;
    while (pop_cnt < p0 + 4) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        timeout_fail("reset_tail_wait");
        break;
      end
    end
    fd0 = fd_cnt;
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_out_last", bus.out_last, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    check("midrst_no_frame_done", fd_cnt - fd0, 0);
    for (int i = 0; i < 7; i++) push(imp_seq[i], i == 6);
    start_frame(1);
    send_bit(1'b1);
    wait_done();
    tick();
    check("post_rst_frame_done_cnt", fd_cnt - fd0, 1);

    // Random frames against the convolution model
    rdy_mode = 2;
    for (int f = 0; f < 2; f++) begin
      int  len;
      bit  b;
      len = (f == 0) ? 1000 : 24;
      for (int k = 0; k < 7; k++) hist[k] = 1'b0;
      fd0 = fd_cnt;
      start_frame(len);
      for (int i = 0; i < len; i++) begin
        b = 1'($urandom_range(0, 1));
        push(ref_sym(b), 1'b0);
        if ($urandom_range(0, 3) == 0) tick();
        send_bit(b);
      end
      for (int i = 0; i < 6; i++) push(ref_sym(1'b0), i == 5);
      wait_done();
      tick();
      check("rand_frame_done_cnt", fd_cnt - fd0, 1);
    end
    rdy_mode = 0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
